sipo_packer: RTL

Byte-to-word packer with an output FIFO. It is the write-side counterpart of the 32-bit-to-byte streamer.
- Accepts the 8-bit JPEG bitstream from the entropy coder / byte stuffer, one byte per din_valid.
- Assembles bytes little-endian into 32-bit words and buffers them in a 2^DEPTH_PWR-deep FIFO.
- Presents the words on a valid/ready interface toward the memory/bus writer.
- A flush input closes a partial word at end of image.

---
 rtl/sipo_pkg.sv | 10 +
 rtl/sipo_word_fifo.sv | 55 +++++
 rtl/sipo_packer.sv | 82 ++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types for the byte-to-word packer.
// One FIFO entry carries a word plus its count of valid low-order bytes.
package sipo_pkg;
   localparam int BYTES_PER_WORD = 4;

   typedef struct packed {
      logic [2:0]  nbytes;
      logic [31:0] data;
   } word_entry_t;
endpackage

// File: rtl/sipo_word_fifo.sv
// Show-ahead FIFO of packed words.
// A push while full is dropped unless a pop frees a slot in the same cycle.
module sipo_word_fifo
   import sipo_pkg::*;
#(
   parameter int DEPTH_PWR = 4
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 push,
   input  word_entry_t          push_data,
   input  logic                 pop,
   output word_entry_t          head,
   output logic                 empty,
   output logic                 full,
   output logic [DEPTH_PWR:0]   level,
   output logic                 drop
);
   localparam int DEPTH = 1 << DEPTH_PWR;

   logic [DEPTH_PWR:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_PWR:0] rd_ptr_q, rd_ptr_d;
   logic               do_pop, do_push;
   word_entry_t        mem_q [DEPTH];

   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[DEPTH_PWR] != rd_ptr_q[DEPTH_PWR]) &&
                (wr_ptr_q[DEPTH_PWR-1:0] == rd_ptr_q[DEPTH_PWR-1:0]);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      drop    = push & ~do_push;
      wr_ptr_d = wr_ptr_q + {{DEPTH_PWR{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{DEPTH_PWR{1'b0}}, do_pop};
      level   = wr_ptr_q - rd_ptr_q;
      head    = mem_q[rd_ptr_q[DEPTH_PWR-1:0]];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[DEPTH_PWR-1:0]] <= push_data;
      end
   end
endmodule

// File: rtl/sipo_packer.sv
// Packs a byte stream little-endian into 32-bit words and queues them
// for the bus writer; flush closes a partial word at end of image.
module sipo_packer
   import sipo_pkg::*;
#(
   parameter int DEPTH_PWR = 4
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [7:0]           din,
   input  logic                 din_valid,
   input  logic                 flush,
   output logic [31:0]          dout,
   output logic [2:0]           dout_bytes,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [DEPTH_PWR:0]   level,
   output logic                 overflow
);
   logic [31:0] asm_q, asm_d, merged;
   logic [1:0]  lane_q, lane_d;
   logic        ovf_q, ovf_d;
   logic [2:0]  fill;
   logic        push, pop;
   word_entry_t push_data, head;
   logic        empty, full, drop;

   always_comb begin
      merged = asm_q;
      if (din_valid) begin
         merged = asm_q | ({24'd0, din} << {lane_q, 3'b000});
      end
      fill   = {1'b0, lane_q} + {2'b00, din_valid};
      asm_d  = merged;
      lane_d = lane_q + {1'b0, din_valid};
      push   = 1'b0;
      // A full word or a flush with any pending byte closes the word.
      if (fill == 3'(BYTES_PER_WORD) || (flush && fill != 3'd0)) begin
         push   = 1'b1;
         asm_d  = '0;
         lane_d = '0;
      end
      push_data.data   = merged;
      push_data.nbytes = fill;
      ovf_d = ovf_q | (full & drop);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         asm_q  <= '0;
         lane_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         asm_q  <= asm_d;
         lane_q <= lane_d;
         ovf_q  <= ovf_d;
      end
   end

   sipo_word_fifo #(
      .DEPTH_PWR (DEPTH_PWR)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full),
      .level     (level),
      .drop      (drop)
   );

   always_comb begin
      pop        = dout_ready & ~empty;
      dout_valid = ~empty;
      dout       = head.data;
      dout_bytes = empty ? 3'd0 : head.nbytes;
      overflow   = ovf_q;
   end
endmodule
